// File: rtl/osd_spi_master.sv
// osd_spi_master
//   SPI master for the OSD chip. Sends a command byte followed by 0..256
//   payload bytes that are fetched one byte ahead from an external byte store.
//   SCK idles low. DI changes on the SCK falling edge so the receiver can
//   sample it on the rising edge.
//
// Ports
//   clk        system clock, rising edge
//   reset_n    asynchronous active-low reset
//   start      transfer request, sampled only while idle
//   cmd        command byte, latched when start is accepted
//   len        payload byte count, latched when start is accepted, clamped to 256
//   byte_addr  index of the payload byte being fetched
//   byte_rd    one-cycle fetch strobe for byte_addr
//   byte_in    payload byte, valid on the cycle after byte_rd
//   busy       high from the accepted start until the inter-transfer gap ends
//   done       one-cycle pulse when SPI_SS3 returns high
//   SPI_SCK    serial clock
//   SPI_SS3    OSD chip select, active low
//   SPI_DI     serial data, MSB first
module osd_spi_master #(
  parameter int CLK_DIV = 4,
  parameter int SS_GAP  = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic [7:0] cmd,
  input  logic [8:0] len,
  output logic [7:0] byte_addr,
  output logic       byte_rd,
  input  logic [7:0] byte_in,
  output logic       busy,
  output logic       done,
  output logic       SPI_SCK,
  output logic       SPI_SS3,
  output logic       SPI_DI
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, LOAD, HOLD, GAP} state_t;

  localparam logic [15:0] LP_HALF    = 16'(CLK_DIV);
  localparam logic [15:0] LP_HALF_M1 = 16'(CLK_DIV - 1);
  localparam logic [15:0] LP_FULL_M1 = 16'(2 * CLK_DIV - 1);
  localparam logic [15:0] LP_GAP_M1  = 16'(SS_GAP - 1);

  state_t      r_state;
  logic [15:0] r_cnt;    // cycle counter within the current phase
  logic [2:0]  r_bit;    // bit index within the current byte (0 = MSB)
  logic [8:0]  r_byte;   // byte index in the transfer, 0 = command byte
  logic [8:0]  r_len;
  logic [7:0]  r_sr;
  logic [7:0]  r_next;   // prefetched payload byte for the next byte slot
  logic        r_rd_d;

  logic [8:0]  w_byte_nx;
  logic        w_more;
  logic        w_fetch_nx;

  assign w_byte_nx  = r_byte + 9'd1;
  // Byte slot r_byte is followed by payload byte r_byte when r_byte < len.
  assign w_more     = (r_byte < r_len);
  assign w_fetch_nx = (w_byte_nx < r_len);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_bit     <= '0;
      r_byte    <= '0;
      r_len     <= '0;
      r_sr      <= '0;
      r_next    <= '0;
      r_rd_d    <= 1'b0;
      byte_addr <= '0;
      byte_rd   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      SPI_SCK   <= 1'b0;
      SPI_SS3   <= 1'b1;
      SPI_DI    <= 1'b0;
    end else begin
      byte_rd <= 1'b0;
      done    <= 1'b0;
      r_rd_d  <= byte_rd;
      if (r_rd_d) r_next <= byte_in;

      case (r_state)
        IDLE: begin
          if (start) begin
            r_len   <= (len > 9'd256) ? 9'd256 : len;
            r_sr    <= cmd;
            SPI_DI  <= cmd[7];
            SPI_SS3 <= 1'b0;
            busy    <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_state <= SETUP;
          end
        end

        // The accept cycle plus CLK_DIV low cycles lead into the first rise.
        SETUP: begin
          if (r_cnt == LP_HALF) begin
            r_cnt   <= '0;
            SPI_SCK <= 1'b1;
            r_state <= SHIFT;
            if (w_more) begin
              byte_rd   <= 1'b1;
              byte_addr <= '0;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        // Bits 0..6 of a byte.
        SHIFT: begin
          if (r_cnt == LP_FULL_M1) begin
            r_cnt   <= '0;
            SPI_SCK <= 1'b1;
            r_bit   <= r_bit + 3'd1;
            if (r_bit == 3'd6) r_state <= LOAD;
          end else begin
            r_cnt <= r_cnt + 16'd1;
            if (r_cnt == LP_HALF_M1) begin
              SPI_SCK <= 1'b0;
              SPI_DI  <= r_sr[6];
              r_sr    <= {r_sr[6:0], 1'b0};
            end
          end
        end

        // Bit 7: same timing as SHIFT, but the falling edge swaps in the
        // prefetched byte so consecutive bytes run back to back.
        LOAD: begin
          if (r_cnt == LP_FULL_M1) begin
            r_cnt <= '0;
            r_bit <= '0;
            if (w_more) begin
              r_byte  <= w_byte_nx;
              SPI_SCK <= 1'b1;
              r_state <= SHIFT;
              if (w_fetch_nx) begin
                byte_rd   <= 1'b1;
                byte_addr <= w_byte_nx[7:0];
              end
            end else begin
              r_state <= HOLD;
            end
          end else begin
            r_cnt <= r_cnt + 16'd1;
            if (r_cnt == LP_HALF_M1) begin
              SPI_SCK <= 1'b0;
              if (w_more) begin
                r_sr   <= r_next;
                SPI_DI <= r_next[7];
              end else begin
                SPI_DI <= 1'b0;
              end
            end
          end
        end

        HOLD: begin
          if (r_cnt == LP_HALF_M1) begin
            r_cnt   <= '0;
            SPI_SS3 <= 1'b1;
            done    <= 1'b1;
            r_state <= GAP;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        GAP: begin
          if (r_cnt == LP_GAP_M1) begin
            r_cnt   <= '0;
            busy    <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_cnt <= r_cnt + 16'd1;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_osd_spi_master.sv
// tb_osd_spi_master
//   Directed bench for osd_spi_master. Instance 0 runs with CLK_DIV=2 and
//   instance 1 with CLK_DIV=4; both use SS_GAP=8. A negedge monitor acts as
//   the SPI receiver and tracks protocol rules, SCK rises, fetches and the
//   SS3-low duration.
module tb_osd_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] start, sck, ss, di, busy, done, rd;
  logic [7:0] cmd  [2];
  logic [8:0] len  [2];
  logic [7:0] addr [2];
  logic [7:0] bin  [2];

  int n_assert = 0;
  int n_fail   = 0;

  osd_spi_master #(.CLK_DIV(2), .SS_GAP(8)) u_dut_d2 (
    .clk(clk), .reset_n(rst_n), .start(start[0]), .cmd(cmd[0]), .len(len[0]),
    .byte_addr(addr[0]), .byte_rd(rd[0]), .byte_in(bin[0]), .busy(busy[0]),
    .done(done[0]), .SPI_SCK(sck[0]), .SPI_SS3(ss[0]), .SPI_DI(di[0])
  );

  osd_spi_master #(.CLK_DIV(4), .SS_GAP(8)) u_dut_d4 (
    .clk(clk), .reset_n(rst_n), .start(start[1]), .cmd(cmd[1]), .len(len[1]),
    .byte_addr(addr[1]), .byte_rd(rd[1]), .byte_in(bin[1]), .busy(busy[1]),
    .done(done[1]), .SPI_SCK(sck[1]), .SPI_SS3(ss[1]), .SPI_DI(di[1])
  );

  // Byte store: answers a fetch of address a with a ^ 0xA5 on the next cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) bin[i] <= addr[i] ^ 8'hA5;
  end

  // Receiver / protocol monitor.
  int         rises    [2] = '{0, 0};
  int         rdn      [2] = '{0, 0};
  int         rd_xfer  [2] = '{0, 0};
  int         addr_err [2] = '{0, 0};
  int         donen    [2] = '{0, 0};
  int         prot_err [2] = '{0, 0};
  int         run      [2] = '{0, 0};
  int         last_run [2] = '{0, 0};
  int         rx_n     [2] = '{0, 0};
  int         rx_bits  [2] = '{0, 0};
  logic [7:0] rx_sh    [2];
  logic [7:0] rx_mem   [2][1024];
  logic [1:0] p_sck = 2'b00;
  logic [1:0] p_ss  = 2'b11;
  logic [1:0] p_di  = 2'b00;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!ss[i] && !p_ss[i] && sck[i] && p_sck[i] && (di[i] !== p_di[i])) prot_err[i]++;
      if (ss[i] && sck[i]) prot_err[i]++;
      if (sck[i] && !p_sck[i]) begin
        rises[i]++;
        rx_sh[i] = {rx_sh[i][6:0], di[i]};
        rx_bits[i]++;
        if (rx_bits[i] == 8) begin
          if (rx_n[i] < 1024) rx_mem[i][rx_n[i]] = rx_sh[i];
          rx_n[i]++;
          rx_bits[i] = 0;
        end
      end
      if (rd[i]) begin
        if (int'(addr[i]) != rd_xfer[i]) addr_err[i]++;
        rd_xfer[i]++;
        rdn[i]++;
      end
      if (done[i]) donen[i]++;
      if (!ss[i]) run[i]++;
      else if (run[i] != 0) begin
        last_run[i] = run[i];
        run[i] = 0;
      end
      if (ss[i]) begin
        rx_bits[i] = 0;
        rd_xfer[i] = 0;
      end
      p_sck[i] = sck[i];
      p_ss[i]  = ss[i];
      p_di[i]  = di[i];
    end
  end

  int b_rise, b_rd, b_done, b_rx;

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic snap(input int i);
    b_rise = rises[i];
    b_rd   = rdn[i];
    b_done = donen[i];
    b_rx   = rx_n[i];
  endtask

  task automatic launch(input int i, input logic [7:0] c, input logic [8:0] l);
    snap(i);
    cmd[i]   = c;
    len[i]   = l;
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
  endtask

  task automatic wait_done(input int i, input int bound);
    for (int c = 0; c < bound && !done[i]; c++) tick();
    chk("done_seen", int'(done[i]), 1);
  endtask

  task automatic wait_gap(input int i);
    int g;
    g = 0;
    while (busy[i] && g < 50) begin
      tick();
      g++;
    end
    chk("gap_cycles", g, 8);
  endtask

  int e;

  initial begin
    rst_n = 1'b1;
    start = 2'b00;
    cmd   = '{8'h00, 8'h00};
    len   = '{9'd0, 9'd0};
    #2 rst_n = 1'b0;
    tick();
    tick();
    chk("rst_ss3",   int'(ss),   3);
    chk("rst_sck",   int'(sck),  0);
    chk("rst_di",    int'(di),   0);
    chk("rst_busy",  int'(busy), 0);
    chk("rst_done",  int'(done), 0);
    chk("rst_rd",    int'(rd),   0);
    chk("rst_addr0", int'(addr[0]), 0);

    // Enable command, no payload, requested together with reset release.
    rst_n = 1'b1;
    launch(0, 8'h41, 9'd0);
    chk("acc_busy", int'(busy[0]), 1);
    chk("acc_ss3",  int'(ss[0]),   0);
    chk("acc_di",   int'(di[0]),   0);
    wait_done(0, 200);
    chk("s1_ss_low", last_run[0], 37);
    chk("s1_rises",  rises[0] - b_rise, 8);
    chk("s1_rd",     rdn[0] - b_rd, 0);
    chk("s1_done",   donen[0] - b_done, 1);
    chk("s1_rx_n",   rx_n[0] - b_rx, 1);
    chk("s1_rx0",    int'(rx_mem[0][b_rx]), 'h41);
    chk("s1_busy_in_gap", int'(busy[0]), 1);
    wait_gap(0);

    // Full 256-byte line write at CLK_DIV=4.
    launch(1, 8'h23, 9'd256);
    wait_done(1, 20000);
    chk("s2_ss_low", last_run[1], 16457);
    chk("s2_rises",  rises[1] - b_rise, 2056);
    chk("s2_rd",     rdn[1] - b_rd, 256);
    chk("s2_addr_err", addr_err[1], 0);
    chk("s2_done",   donen[1] - b_done, 1);
    chk("s2_rx_n",   rx_n[1] - b_rx, 257);
    chk("s2_rx_cmd", int'(rx_mem[1][b_rx]), 'h23);
    chk("s2_rx_p0",  int'(rx_mem[1][b_rx + 1]), 'hA5);
    chk("s2_rx_p255", int'(rx_mem[1][b_rx + 256]), 'h5A);
    e = 0;
    for (int k = 0; k < 256; k++) begin
      logic [7:0] exp_b;
      exp_b = 8'(k) ^ 8'hA5;
      if (rx_mem[1][b_rx + 1 + k] !== exp_b) e++;
    end
    chk("s2_payload_errs", e, 0);
    wait_gap(1);

    // start held high for the whole transfer; cmd/len changed mid-flight.
    snap(0);
    cmd[0]   = 8'h20;
    len[0]   = 9'd4;
    start[0] = 1'b1;
    tick();
    cmd[0] = 8'hFF;
    len[0] = 9'd7;
    wait_done(0, 400);
    chk("s3_ss_low", last_run[0], 165);
    chk("s3_rises",  rises[0] - b_rise, 40);
    chk("s3_rd",     rdn[0] - b_rd, 4);
    chk("s3_done",   donen[0] - b_done, 1);
    chk("s3_rx_n",   rx_n[0] - b_rx, 5);
    chk("s3_rx_cmd", int'(rx_mem[0][b_rx]), 'h20);
    chk("s3_rx_p0",  int'(rx_mem[0][b_rx + 1]), 'hA5);
    chk("s3_rx_p1",  int'(rx_mem[0][b_rx + 2]), 'hA4);
    chk("s3_rx_p2",  int'(rx_mem[0][b_rx + 3]), 'hA7);
    chk("s3_rx_p3",  int'(rx_mem[0][b_rx + 4]), 'hA6);
    wait_gap(0);
    start[0] = 1'b0;
    tick();
    chk("s3_no_queue_busy", int'(busy[0]), 0);
    chk("s3_no_queue_ss3",  int'(ss[0]),   1);

    // Reset during bit 3 of payload byte 1 (transfer byte 2).
    launch(0, 8'h41, 9'd4);
    for (int c = 0; c < 500 && (rises[0] - b_rise) < 20; c++) tick();
    chk("s4_pre_sck",  int'(sck[0]), 1);
    chk("s4_pre_ss3",  int'(ss[0]),  0);
    chk("s4_pre_addr", int'(addr[0]), 2);
    #2 rst_n = 1'b0;
    #1;
    chk("s4_rst_ss3",  int'(ss[0]),   1);
    chk("s4_rst_sck",  int'(sck[0]),  0);
    chk("s4_rst_di",   int'(di[0]),   0);
    chk("s4_rst_busy", int'(busy[0]), 0);
    chk("s4_rst_addr", int'(addr[0]), 0);
    chk("s4_rst_rd",   int'(rd[0]),   0);
    tick();
    rst_n = 1'b1;
    tick();
    launch(0, 8'h40, 9'd0);
    wait_done(0, 200);
    chk("s4_ss_low", last_run[0], 37);
    chk("s4_rises",  rises[0] - b_rise, 8);
    chk("s4_rx_n",   rx_n[0] - b_rx, 1);
    chk("s4_rx0",    int'(rx_mem[0][b_rx]), 'h40);
    wait_gap(0);

    // Oversized length behaves as 256.
    launch(0, 8'h81, 9'd300);
    chk("s5_first_di", int'(di[0]), 1);
    wait_done(0, 10000);
    chk("s5_ss_low", last_run[0], 8229);
    chk("s5_rises",  rises[0] - b_rise, 2056);
    chk("s5_rd",     rdn[0] - b_rd, 256);
    chk("s5_addr_err", addr_err[0], 0);
    chk("s5_rx_n",   rx_n[0] - b_rx, 257);
    chk("s5_rx_cmd", int'(rx_mem[0][b_rx]), 'h81);
    chk("s5_rx_last", int'(rx_mem[0][b_rx + 256]), 'h5A);
    wait_gap(0);

    chk("prot_err_d2", prot_err[0], 0);
    chk("prot_err_d4", prot_err[1], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
